// File: rtl/rom_pkg.sv
// Shared defaults and FSM state type for the ROM burst reader.
package rom_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request, ROM read port and output stream of the burst reader, bundled.
// Stream handshake: a word transfers on a clock edge where out_valid and
// out_ready are both 1; once raised, out_valid and out_data hold until then.
interface rom_burst_reader_if
  import rom_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   burst_len;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, burst_len, rom_data, out_ready,
    output rom_en, rom_addr, out_valid, out_data, busy, done
  );

  modport slave (
    output start, start_addr, burst_len, rom_data, out_ready,
    input  rom_en, rom_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible whenever count != 0.
module sync_fifo_fwft #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push in the same cycle as a pop.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/rom_burst_reader.sv
// Streams a burst of consecutive ROM words (address wraps) through a small
// FWFT buffer, issuing reads only when a buffer slot is guaranteed.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_burst_reader_if.master   bus,
  output state_t               state_dbg
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              in_flight_q;
  logic              done_q, done_d;
  logic              rom_en;
  logic              pop;
  logic              fifo_empty;
  logic              unused_fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit;

  assign pop = !fifo_empty && bus.out_ready;
  // Slots already committed: buffered words plus the read in flight, less the
  // word leaving this cycle.
  assign credit = {1'b0, fifo_count} + (CNT_W+1)'(in_flight_q) - (CNT_W+1)'(pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    rom_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            addr_d  = bus.start_addr;
            rem_d   = bus.burst_len;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (credit < (CNT_W+1)'(FIFO_DEPTH)) begin
          rom_en = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Everything is issued; finish when the only remaining word leaves.
        if (!in_flight_q && pop && fifo_count == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      in_flight_q <= rom_en;
      done_q      <= done_d;
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (bus.rom_data),
    .pop       (pop),
    .pop_data  (bus.out_data),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: ROM returns 16'h1000+addr one cycle after rom_en.
module tb_rom_burst_reader;
  import rom_pkg::*;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int BUDGET     = 80;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;
  logic [DATA_W-1:0] rom_q;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] obs_q[$];
  int obs_done_cnt, obs_done_cycle, obs_last_hs, obs_first_valid;
  int obs_issued, obs_max_out, obs_unstable, obs_busy_at_done, obs_valid_cnt;

  rom_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rom_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / ROM model (poison word when no read was enabled)
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= bus.rom_en ? (16'h1000 + DATA_W'(bus.rom_addr)) : 16'hDEAD;
  assign bus.rom_data = rom_q;

  // reference model: words of a wrapping burst
  function automatic void model_burst(input int addr, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(16'h1000 + DATA_W'((addr + i) % (1 << ADDR_W)));
  endfunction

  // driver: runs one burst, records observations only
  task automatic drive_burst(input int addr, input int len, input int stall_lo, input int stall_hi,
                             input int rand_ready, input int rst_at_words, input int restart_cyc);
    int issued, accepted, post_done;
    logic prev_hold;
    logic [DATA_W-1:0] prev_data;
    obs_q.delete();
    obs_done_cnt = 0; obs_done_cycle = -1; obs_last_hs = -1; obs_first_valid = -1;
    obs_issued = 0; obs_max_out = 0; obs_unstable = 0; obs_busy_at_done = 0; obs_valid_cnt = 0;
    issued = 0; accepted = 0; post_done = 0; prev_hold = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cyc == 0) begin
        bus.start = 1'b1; bus.start_addr = ADDR_W'(addr); bus.burst_len = (ADDR_W+1)'(len);
      end else if (cyc == restart_cyc) begin
        bus.start = 1'b1; bus.start_addr = 3'd5; bus.burst_len = 4'd3;
      end
      if (cyc >= stall_lo && cyc <= stall_hi) bus.out_ready = 1'b0;
      else if (rand_ready != 0)               bus.out_ready = ($urandom_range(0, 3) != 0);
      else                                    bus.out_ready = 1'b1;
      if (rst_at_words >= 0 && accepted >= rst_at_words) begin
        rst = 1'b1; bus.out_ready = 1'b0; bus.start = 1'b0;
        break;
      end
      #1;
      if (bus.out_valid) obs_valid_cnt++;
      if (bus.out_valid && obs_first_valid < 0) obs_first_valid = cyc;
      if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) obs_unstable++;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.done) begin
        obs_done_cnt++; obs_done_cycle = cyc;
        if (bus.busy) obs_busy_at_done = 1;
      end
      if (bus.rom_en) begin issued++; obs_issued++; end
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back(bus.out_data); accepted++; obs_last_hs = cyc;
      end
      if (issued - accepted > obs_max_out) obs_max_out = issued - accepted;
      if (obs_done_cnt > 0) post_done++;
      if (post_done > 3) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.start_addr = '0; bus.burst_len = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_compared++;
    if ({bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.busy, bus.done} !== '0) begin
      n_mismatched++;
      $display("FAIL reset_outputs got en=%0b addr=%0d v=%0b d=%h busy=%0b done=%0b want all 0",
               bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.busy, bus.done);
    end
    n_compared++;
    if (state_dbg !== S_IDLE) begin
      n_mismatched++; $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    model_burst(2, 4);
    drive_burst(2, 4, -1, -1, 0, -1, -1);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mismatched++; $display("FAIL basic_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_compared++;
    if (obs_first_valid != 3) begin
      n_mismatched++; $display("FAIL basic_first_valid got cycle %0d want 3", obs_first_valid);
    end
    n_compared++;
    if (obs_last_hs != 6) begin
      n_mismatched++; $display("FAIL basic_last_word got cycle %0d want 6", obs_last_hs);
    end
    n_compared++;
    if (obs_done_cnt != 1 || obs_done_cycle != 7 || obs_busy_at_done != 0) begin
      n_mismatched++;
      $display("FAIL basic_done got cnt=%0d cyc=%0d busy=%0d want 1/7/0", obs_done_cnt, obs_done_cycle, obs_busy_at_done);
    end
  endtask

  task automatic test_wrap;
    model_burst(6, 5);
    drive_burst(6, 5, -1, -1, 0, -1, -1);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mismatched++; $display("FAIL wrap_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_compared++;
    if (obs_done_cnt != 1 || obs_done_cycle != obs_last_hs + 1) begin
      n_mismatched++;
      $display("FAIL wrap_done got cnt=%0d cyc=%0d want 1/%0d", obs_done_cnt, obs_done_cycle, obs_last_hs + 1);
    end
  endtask

  task automatic test_stall;
    model_burst(1, 8);
    drive_burst(1, 8, 3, 7, 0, -1, -1);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mismatched++; $display("FAIL stall_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_compared++;
    if (obs_max_out > FIFO_DEPTH) begin
      n_mismatched++; $display("FAIL stall_outstanding got %0d want <= %0d", obs_max_out, FIFO_DEPTH);
    end
    n_compared++;
    if (obs_unstable != 0) begin
      n_mismatched++; $display("FAIL stall_hold got %0d changes want 0", obs_unstable);
    end
    n_compared++;
    if (obs_done_cnt != 1 || obs_done_cycle != obs_last_hs + 1) begin
      n_mismatched++;
      $display("FAIL stall_done got cnt=%0d cyc=%0d want 1/%0d", obs_done_cnt, obs_done_cycle, obs_last_hs + 1);
    end
  endtask

  task automatic test_zero_len;
    drive_burst(3, 0, -1, -1, 0, -1, -1);
    n_compared++;
    if (obs_done_cnt != 1 || obs_done_cycle != 1) begin
      n_mismatched++; $display("FAIL zero_done got cnt=%0d cyc=%0d want 1/1", obs_done_cnt, obs_done_cycle);
    end
    n_compared++;
    if (obs_issued != 0 || obs_valid_cnt != 0) begin
      n_mismatched++; $display("FAIL zero_activity got reads=%0d valids=%0d want 0/0", obs_issued, obs_valid_cnt);
    end
    n_compared++;
    if (obs_busy_at_done != 0) begin
      n_mismatched++; $display("FAIL zero_busy got %0d want 0", obs_busy_at_done);
    end
  endtask

  task automatic test_reset_mid_burst;
    int bad;
    model_burst(4, 2);
    drive_burst(4, 6, -1, -1, 0, 2, -1);
    @(negedge clk);
    #1;
    n_compared++;
    if ({bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.busy, bus.done} !== '0 || state_dbg !== S_IDLE) begin
      n_mismatched++;
      $display("FAIL midrst_outputs got en=%0b addr=%0d v=%0b d=%h busy=%0b done=%0b st=%0d want all 0",
               bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.busy, bus.done, state_dbg);
    end
    n_compared++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      n_mismatched++; $display("FAIL midrst_prefix got %0d words want 2 (%h %h)", obs_q.size(), exp_q[0], exp_q[1]);
    end
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.out_valid || bus.busy) bad++;
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++; $display("FAIL midrst_quiet got %0d active cycles want 0", bad);
    end
    model_burst(0, 2);
    drive_burst(0, 2, -1, -1, 0, -1, -1);
    n_compared++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || obs_done_cnt != 1) begin
      n_mismatched++;
      $display("FAIL midrst_new_burst got %0d words done=%0d want 1000 1001 done=1", obs_q.size(), obs_done_cnt);
    end
  endtask

  task automatic test_start_while_busy;
    model_burst(2, 4);
    drive_burst(2, 4, -1, -1, 0, -1, 4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL busy_start_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mismatched++; $display("FAIL busy_start_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_compared++;
    if (obs_done_cnt != 1 || obs_done_cycle != 7) begin
      n_mismatched++; $display("FAIL busy_start_done got cnt=%0d cyc=%0d want 1/7", obs_done_cnt, obs_done_cycle);
    end
  endtask

  task automatic test_random;
    int addr, len;
    for (int b = 0; b < 8; b++) begin
      addr = $urandom_range(0, 7);
      len  = $urandom_range(1, 8);
      model_burst(addr, len);
      drive_burst(addr, len, -1, -1, 1, -1, -1);
      n_compared++;
      if (obs_q.size() != exp_q.size()) begin
        n_mismatched++; $display("FAIL rand%0d_count got %0d want %0d", b, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_compared++;
        if (obs_q[i] !== exp_q[i]) begin
          n_mismatched++; $display("FAIL rand%0d_word[%0d] got %h want %h", b, i, obs_q[i], exp_q[i]);
        end
      end
      n_compared++;
      if (obs_done_cnt != 1 || obs_done_cycle != obs_last_hs + 1 || obs_max_out > FIFO_DEPTH || obs_unstable != 0) begin
        n_mismatched++;
        $display("FAIL rand%0d_ctrl got done=%0d@%0d out=%0d unstable=%0d want 1@%0d <=%0d 0",
                 b, obs_done_cnt, obs_done_cycle, obs_max_out, obs_unstable, obs_last_hs + 1, FIFO_DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid_burst();
    test_start_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
